// File: rtl/y86_mon_pkg.sv
// rtl/y86_mon_pkg.sv - shared encodings for the Y86 run monitor
// Purpose: write-back status codes, exit codes, controller state and run mode
// types used by y86_run_monitor. No ports.
package y86_mon_pkg;

  // Write-back stage status, as produced by the core
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Latched exit codes; 1..3 deliberately equal the faulting status value
  localparam logic [2:0] EXIT_NONE    = 3'd0;
  localparam logic [2:0] EXIT_HLT     = 3'd1;
  localparam logic [2:0] EXIT_ADR     = 3'd2;
  localparam logic [2:0] EXIT_INS     = 3'd3;
  localparam logic [2:0] EXIT_TIMEOUT = 3'd4;
  localparam logic [2:0] EXIT_ABORT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'd0,
    MODE_STEPN    = 2'd1,
    MODE_SINGLE   = 2'd2,
    MODE_FREE_ALT = 2'd3
  } mode_e;

  function automatic logic is_step_mode(mode_e m);
    return (m == MODE_STEPN) || (m == MODE_SINGLE);
  endfunction

endpackage

// File: rtl/y86_sat_counter.sv
// rtl/y86_sat_counter.sv - saturating load/step counter
// Purpose: CW-wide counter with synchronous load and step enable. Up variant
// sticks at all-ones, down variant (DOWN=1) sticks at zero; load wins over step.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count -> 0)
//   load_i       load load_val_i this cycle
//   load_val_i   value to load
//   en_i         step by one (toward the saturation limit)
//   count_o      current count
module y86_sat_counter #(
  parameter int CW   = 32,
  parameter bit DOWN = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count_q, count_d, stepped;

  always_comb begin
    if (DOWN) begin
      stepped = (count_q == '0) ? count_q : count_q - ONE;
    end else begin
      stepped = (&count_q) ? count_q : count_q + ONE;
    end
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = stepped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/y86_run_monitor.sv
// rtl/y86_run_monitor.sv - run controller and retirement monitor for the Y86 core
// Purpose: gates pipeline advance via cpu_en, supports free-run / step-N /
// single-step, counts active cycles and retired instructions, and stops on
// write-back fault, timeout or abort with a latched exit code.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch (IDLE/DONE) or resume (PAUSE) pulse
//   mode, step_count  run mode and step budget, sampled on start
//   abort             level abort request
//   W_status, W_valid write-back status and slot-valid from the core
//   cpu_en            registered pipeline advance enable
//   running, done     state flags
//   exit_code         latched termination reason
//   cycle_count       active cycles since launch
//   retire_count      AOK instructions retired since launch
module y86_run_monitor
  import y86_mon_pkg::*;
#(
  parameter int CW         = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] step_count,
  input  logic          abort,
  input  logic [1:0]    W_status,
  input  logic          W_valid,
  output logic          cpu_en,
  output logic          running,
  output logic          done,
  output logic [2:0]    exit_code,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] retire_count
);

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam bit            TIMEOUT_ON = (MAX_CYCLES > 0);
  // Timeout fires in the active cycle that brings cycle_count up to MAX_CYCLES
  localparam logic [CW-1:0] TIMEOUT_AT = (MAX_CYCLES > 0) ? CW'(MAX_CYCLES - 1) : '0;

  state_e        state_q, state_d;
  logic [2:0]    exit_q, exit_d;
  logic          step_mode_q, step_mode_d;
  logic          cpu_en_q;

  logic          launch, resume;
  logic          cyc_en, ret_en, rem_en;
  logic [CW-1:0] rem_load_val;
  logic [CW-1:0] cyc_q, ret_q, rem_q;
  logic          fault, timeout_hit;
  mode_e         mode_v;

  assign mode_v      = mode_e'(mode);
  assign fault       = W_valid && (W_status != STAT_AOK);
  assign timeout_hit = TIMEOUT_ON && (cyc_q >= TIMEOUT_AT);

  always_comb begin
    state_d      = state_q;
    exit_d       = exit_q;
    step_mode_d  = step_mode_q;
    launch       = 1'b0;
    resume       = 1'b0;
    cyc_en       = 1'b0;
    ret_en       = 1'b0;
    rem_en       = 1'b0;

    // Remaining budget for a launch/resume; free-run parks it at all-ones
    if (mode_v == MODE_STEPN) begin
      rem_load_val = (step_count == '0) ? ONE : step_count;
    end else if (mode_v == MODE_SINGLE) begin
      rem_load_val = ONE;
    end else begin
      rem_load_val = '1;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch      = 1'b1;
          exit_d      = EXIT_NONE;
          step_mode_d = is_step_mode(mode_v);
          state_d     = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start) begin
          resume      = 1'b1;
          step_mode_d = is_step_mode(mode_v);
          state_d     = ST_RUN;
        end else if (abort) begin
          exit_d  = EXIT_ABORT;
          state_d = ST_DONE;
        end
      end
      ST_RUN: begin
        // Every RUN cycle is an active cycle since cpu_en tracks RUN
        cyc_en = 1'b1;
        ret_en = W_valid && (W_status == STAT_AOK);
        rem_en = step_mode_q;
        if (fault) begin
          exit_d  = {1'b0, W_status};
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          exit_d  = EXIT_TIMEOUT;
          state_d = ST_DONE;
        end else if (abort) begin
          exit_d  = EXIT_ABORT;
          state_d = ST_DONE;
        end else if (step_mode_q && (rem_q <= ONE)) begin
          state_d = ST_PAUSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      exit_q      <= EXIT_NONE;
      step_mode_q <= 1'b0;
      cpu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exit_q      <= exit_d;
      step_mode_q <= step_mode_d;
      cpu_en_q    <= (state_d == ST_RUN);
    end
  end

  y86_sat_counter #(.CW(CW), .DOWN(1'b0)) u_cycle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (launch),
    .load_val_i ('0),
    .en_i       (cyc_en),
    .count_o    (cyc_q)
  );

  y86_sat_counter #(.CW(CW), .DOWN(1'b0)) u_retire_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (launch),
    .load_val_i ('0),
    .en_i       (ret_en),
    .count_o    (ret_q)
  );

  y86_sat_counter #(.CW(CW), .DOWN(1'b1)) u_remaining_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (launch || resume),
    .load_val_i (rem_load_val),
    .en_i       (rem_en),
    .count_o    (rem_q)
  );

  assign cpu_en       = cpu_en_q;
  assign running      = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign exit_code    = exit_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;

endmodule

// File: tb/tb_y86_run_monitor.sv
// tb/tb_y86_run_monitor.sv - directed self-checking bench for y86_run_monitor
module tb_y86_run_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] step_count;
  logic        abort;
  logic [1:0]  W_status;
  logic        W_valid;
  logic        cpu_en;
  logic        running;
  logic        done;
  logic [2:0]  exit_code;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  int checks   = 0;
  int failures = 0;
  int pulses;

  y86_run_monitor #(.CW(32), .MAX_CYCLES(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .step_count   (step_count),
    .abort        (abort),
    .W_status     (W_status),
    .W_valid      (W_valid),
    .cpu_en       (cpu_en),
    .running      (running),
    .done         (done),
    .exit_code    (exit_code),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic en, input logic run,
                            input logic dn, input logic [2:0] code,
                            input logic [31:0] cyc, input logic [31:0] ret);
    chk({tag, ".cpu_en"}, 32'(cpu_en), 32'(en));
    chk({tag, ".running"}, 32'(running), 32'(run));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".exit"}, 32'(exit_code), 32'(code));
    chk({tag, ".cycles"}, cycle_count, cyc);
    chk({tag, ".retired"}, retire_count, ret);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; step_count = 32'd0;
    abort = 1'b0; W_status = 2'd0; W_valid = 1'b0;
    #1;
    chk_status("reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_status("idle_abort", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    // free-run: 7 AOK retirements then HLT
    start = 1'b1; mode = 2'd0; W_valid = 1'b1; W_status = 2'd0;
    step();
    start = 1'b0;
    chk_status("fr_launch", 1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (7) step();
    chk_status("fr_7aok", 1'b1, 1'b1, 1'b0, 3'd0, 32'd7, 32'd7);
    W_status = 2'd1;
    step();
    W_valid = 1'b0; W_status = 2'd0;
    chk_status("fr_hlt", 1'b0, 1'b0, 1'b1, 3'd1, 32'd8, 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_status("done_abort_hold", 1'b0, 1'b0, 1'b1, 3'd1, 32'd8, 32'd7);

    // step-N with N=5: exactly five active cycles, then PAUSE
    start = 1'b1; mode = 2'd1; step_count = 32'd5; W_valid = 1'b1; W_status = 2'd0;
    step();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_en) pulses++;
      step();
    end
    chk("stepn_pulses", 32'(pulses), 32'd5);
    chk_status("stepn_pause", 1'b0, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5);

    // resume single-step: one more cycle
    start = 1'b1; mode = 2'd2;
    step();
    start = 1'b0;
    chk("single_en", 32'(cpu_en), 32'd1);
    step();
    chk_status("single_pause", 1'b0, 1'b0, 1'b0, 3'd0, 32'd6, 32'd6);

    // resume step-N with step_count=0 behaves as one step
    start = 1'b1; mode = 2'd1; step_count = 32'd0;
    step();
    start = 1'b0;
    step();
    chk_status("step0_pause", 1'b0, 1'b0, 1'b0, 3'd0, 32'd7, 32'd7);

    // abort in PAUSE keeps counters
    W_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_status("pause_abort", 1'b0, 1'b0, 1'b1, 3'd5, 32'd7, 32'd7);

    // relaunch from DONE clears counters; bubbles with INS never fault -> timeout
    start = 1'b1; mode = 2'd0; W_valid = 1'b0; W_status = 2'd3;
    step();
    start = 1'b0;
    chk_status("to_launch", 1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (19) step();
    chk_status("to_19", 1'b1, 1'b1, 1'b0, 3'd0, 32'd19, 32'd0);
    step();
    chk_status("to_done", 1'b0, 1'b0, 1'b1, 3'd4, 32'd20, 32'd0);

    // ADR fault, timeout and abort on one edge: fault wins
    start = 1'b1; mode = 2'd0; W_valid = 1'b1; W_status = 2'd0;
    step();
    start = 1'b0;
    repeat (19) step();
    chk_status("prio_19", 1'b1, 1'b1, 1'b0, 3'd0, 32'd19, 32'd19);
    W_status = 2'd2; abort = 1'b1;
    step();
    abort = 1'b0; W_valid = 1'b0; W_status = 2'd0;
    chk_status("prio_adr", 1'b0, 1'b0, 1'b1, 3'd2, 32'd20, 32'd19);

    // start during RUN ignored; abort in RUN ends with code 5
    start = 1'b1; mode = 2'd0;
    step();
    mode = 2'd2;
    step();
    start = 1'b0;
    step();
    chk_status("run_start_ign", 1'b1, 1'b1, 1'b0, 3'd0, 32'd2, 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_status("run_abort", 1'b0, 1'b0, 1'b1, 3'd5, 32'd3, 32'd0);

    // asynchronous reset mid-RUN
    start = 1'b1; mode = 2'd0; W_valid = 1'b1; W_status = 2'd0;
    step();
    start = 1'b0;
    repeat (3) step();
    chk_status("pre_rst", 1'b1, 1'b1, 1'b0, 3'd0, 32'd3, 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_status("async_rst", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    W_status = 2'd1;
    step();
    W_valid = 1'b0; W_status = 2'd0;
    chk_status("relaunch", 1'b0, 1'b0, 1'b1, 3'd1, 32'd3, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
